// File: rtl/bf16_mac_pkg_44.sv
// +----------------------------------------------------------------------------+
// | Module      : bf16_mac_pkg_44                                              |
// | Description : Shared types and constants for the BF16 MAC and its loader.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package bf16_mac_pkg_44;
   localparam int NUM_ELEMENTS = 12;
   localparam int DATA_W       = 16;

   typedef logic [15:0] bf16_t;
   localparam bf16_t c_bf16_zero = 16'h0000;

   typedef logic [2:0] loader_state_t;
   localparam loader_state_t c_st_fill   = 3'd0;
   localparam loader_state_t c_st_drop   = 3'd1;
   localparam loader_state_t c_st_start  = 3'd2;
   localparam loader_state_t c_st_busy   = 3'd3;
   localparam loader_state_t c_st_result = 3'd4;
endpackage

`default_nettype wire

// File: rtl/bf16_vector_loader_44.sv
// +----------------------------------------------------------------------------+
// | Module      : bf16_vector_loader_44                                        |
// | Description : Assembles BF16 operand frames, drives the MAC, returns result|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module bf16_vector_loader_44 #(
   parameter int NUM_ELEMENTS   = bf16_mac_pkg_44::NUM_ELEMENTS,
   parameter int DATA_W         = bf16_mac_pkg_44::DATA_W,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic                             clk_44,
   input  logic                             rst_44,
   input  logic                             in_valid_44,
   output logic                             in_ready_44,
   input  logic [DATA_W-1:0]                in_a_44,
   input  logic [DATA_W-1:0]                in_b_44,
   input  logic                             in_last_44,
   output logic [NUM_ELEMENTS*DATA_W-1:0]   vector_a_44,
   output logic [NUM_ELEMENTS*DATA_W-1:0]   vector_b_44,
   output logic                             start_computation_44,
   input  logic                             computation_done_44,
   input  logic [DATA_W-1:0]                result_44,
   output logic                             res_valid_44,
   input  logic                             res_ready_44,
   output logic [DATA_W-1:0]                res_data_44,
   output logic                             err_short_44,
   output logic                             err_overrun_44,
   output logic                             err_timeout_44
);
   import bf16_mac_pkg_44::*;

   localparam int IDX_W = $clog2(NUM_ELEMENTS + 1);
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IDX_W-1:0] c_last_idx     = IDX_W'(NUM_ELEMENTS - 1);
   localparam logic [TMR_W-1:0] c_guard        = TMR_W'(2);
   localparam logic [TMR_W-1:0] c_timeout_last = TMR_W'(TIMEOUT_CYCLES - 1);

   loader_state_t      r_state;
   loader_state_t      w_next_state;
   logic [IDX_W-1:0]   r_idx;
   logic [TMR_W-1:0]   r_timer;
   logic [DATA_W-1:0]  r_bank_a [NUM_ELEMENTS];
   logic [DATA_W-1:0]  r_bank_b [NUM_ELEMENTS];
   logic               r_in_ready;
   logic               r_start;
   logic               r_res_valid;
   logic [DATA_W-1:0]  r_res_data;
   logic               r_err_short;
   logic               r_err_overrun;
   logic               r_err_timeout;
   logic               w_fire;
   logic               w_done_ok;

   assign w_fire    = in_valid_44 && r_in_ready;
   // Done is only trusted once the stale-done guard window has passed.
   assign w_done_ok = computation_done_44 && (r_timer >= c_guard);

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_st_fill: begin
            if (w_fire) begin
               if (in_last_44)
                  w_next_state = c_st_start;
               else if (r_idx == c_last_idx)
                  w_next_state = c_st_drop;
            end
         end
         c_st_drop:   if (w_fire && in_last_44) w_next_state = c_st_start;
         c_st_start:  w_next_state = c_st_busy;
         c_st_busy: begin
            if (w_done_ok)
               w_next_state = c_st_result;
            else if (r_timer == c_timeout_last)
               w_next_state = c_st_fill;
         end
         c_st_result: if (res_ready_44) w_next_state = c_st_fill;
         default:     w_next_state = c_st_fill;
      endcase
   end

   always_ff @(posedge clk_44 or posedge rst_44) begin
      if (rst_44) begin
         r_state       <= c_st_fill;
         r_idx         <= '0;
         r_timer       <= '0;
         r_in_ready    <= 1'b0;
         r_start       <= 1'b0;
         r_res_valid   <= 1'b0;
         r_res_data    <= '0;
         r_err_short   <= 1'b0;
         r_err_overrun <= 1'b0;
         r_err_timeout <= 1'b0;
         for (int i = 0; i < NUM_ELEMENTS; i++) begin
            r_bank_a[i] <= '0;
            r_bank_b[i] <= '0;
         end
      end else begin
         r_state     <= w_next_state;
         r_in_ready  <= (w_next_state == c_st_fill) || (w_next_state == c_st_drop);
         r_start     <= (w_next_state == c_st_start);
         r_res_valid <= (w_next_state == c_st_result);
         case (r_state)
            c_st_fill: begin
               if (w_fire) begin
                  // A short frame zero-fills the tail so stale operands never reach the MAC.
                  for (int i = 0; i < NUM_ELEMENTS; i++) begin
                     if (IDX_W'(i) == r_idx) begin
                        r_bank_a[i] <= in_a_44;
                        r_bank_b[i] <= in_b_44;
                     end else if (in_last_44 && (IDX_W'(i) > r_idx)) begin
                        r_bank_a[i] <= DATA_W'(c_bf16_zero);
                        r_bank_b[i] <= DATA_W'(c_bf16_zero);
                     end
                  end
                  r_idx <= r_idx + 1'b1;
                  if (in_last_44 && (r_idx != c_last_idx))
                     r_err_short <= 1'b1;
                  if (!in_last_44 && (r_idx == c_last_idx))
                     r_err_overrun <= 1'b1;
               end
            end
            c_st_start: begin
               r_timer <= '0;
               r_idx   <= '0;
            end
            c_st_busy: begin
               if (w_done_ok)
                  r_res_data <= result_44;
               else if (r_timer == c_timeout_last)
                  r_err_timeout <= 1'b1;
               else
                  r_timer <= r_timer + 1'b1;
            end
            default: ;
         endcase
      end
   end

   for (genvar g = 0; g < NUM_ELEMENTS; g++) begin : g_pack
      assign vector_a_44[g*DATA_W +: DATA_W] = r_bank_a[g];
      assign vector_b_44[g*DATA_W +: DATA_W] = r_bank_b[g];
   end

   assign in_ready_44          = r_in_ready;
   assign start_computation_44 = r_start;
   assign res_valid_44         = r_res_valid;
   assign res_data_44          = r_res_data;
   assign err_short_44         = r_err_short;
   assign err_overrun_44       = r_err_overrun;
   assign err_timeout_44       = r_err_timeout;
endmodule

`default_nettype wire

// File: doc/bf16_vector_loader_44.md
# bf16_vector_loader_44

Upstream feeder for the BF16 dot-product MAC (`BF16DotProduct_44`).
- Accepts a stream of BF16 operand pairs (A[i], B[i]) over a valid/ready handshake and assembles them into the 12-element operand banks.
- Issues a one-cycle `start_computation_44` and holds the banks stable while the MAC runs.
- Captures `result_44` when the MAC reports done, and returns it on a valid/ready result port.
- Provides frame-error handling (short/long frames) and a MAC-hang timeout.

## Interface
Parameters:
- NUM_ELEMENTS, 12, operand pairs per frame; also the MAC vector length.
- DATA_W, 16, BF16 word width.
- TIMEOUT_CYCLES, 1000, maximum BUSY cycles before abort.

Ports:
- clk_44  in  1  sole clock, rising edge.
- rst_44  in  1  reset; asynchronous, active-high.
- in_valid_44  in  1  operand pair valid.
- in_ready_44  out  1  loader accepts a pair this cycle.
- in_a_44  in  DATA_W  BF16 element of vector A.
- in_b_44  in  DATA_W  BF16 element of vector B.
- in_last_44  in  1  marks the final pair of a frame.
- vector_a_44  out  DATA_W x NUM_ELEMENTS  operand bank A to the MAC.
- vector_b_44  out  DATA_W x NUM_ELEMENTS  operand bank B to the MAC.
- start_computation_44  out  1  one-cycle start pulse to the MAC.
- computation_done_44  in  1  MAC done (level).
- result_44  in  DATA_W  MAC BF16 result.
- res_valid_44  out  1  result available.
- res_ready_44  in  1  consumer accepts the result.
- res_data_44  out  DATA_W  captured result.
- err_short_44  out  1  sticky: frame ended before NUM_ELEMENTS pairs.
- err_overrun_44  out  1  sticky: more than NUM_ELEMENTS pairs arrived before `in_last_44`.
- err_timeout_44  out  1  sticky: MAC did not finish within TIMEOUT_CYCLES.

## Operation
- States: FILL, DROP, START, BUSY, RESULT. Reset state is FILL.
- FILL:
  - `in_ready_44`=1.
  - Each handshake (valid&&ready) writes pair to index `idx`, then increments `idx` (width $clog2(NUM_ELEMENTS+1)).
  - `in_last_44` with idx<NUM_ELEMENTS-1: zero-fill entries idx+1..NUM_ELEMENTS-1 (0x0000), set `err_short_44`, go START.
  - Accept at idx=NUM_ELEMENTS-1 with `in_last_44`=1: go START.
  - Accept at idx=NUM_ELEMENTS-1 with `in_last_44`=0: set `err_overrun_44`, go DROP.
- DROP:
  - `in_ready_44`=1; beats are discarded and banks are untouched.
  - On a handshake carrying `in_last_44`, go START.
- START:
  - `start_computation_44`=1 for exactly this cycle.
  - Clear the timeout counter; go BUSY.
- BUSY:
  - `in_ready_44`=0; banks held constant.
  - `computation_done_44` is ignored for the first 2 BUSY cycles (stale-done guard).
  - After the guard, the first cycle with done=1 captures `result_44` into `res_data_44` and goes RESULT.
  - If the counter reaches TIMEOUT_CYCLES first: set `err_timeout_44`, go FILL, emit no result.
- RESULT:
  - `res_valid_44`=1; `res_data_44` stable.
  - On `res_ready_44`, go FILL and reset idx to 0.
- Error flags clear only on reset.
- Banks are not cleared between frames; every frame overwrites or zero-fills all NUM_ELEMENTS entries before START.
- No arithmetic on data; operands pass through bit-exact.

## Timing
- Reset values (asserted asynchronously):
  - All outputs 0: `in_ready_44`, `start_computation_44`, `res_valid_44`, `res_data_44`, all bank entries, all error flags.
  - `in_ready_44` rises on the first clock edge after `rst_44` deasserts.
- Outputs are registered.
- Last accepted beat at edge N → `start_computation_44` high during cycle N+1 → BUSY from N+2.
- Done sampled at edge M (M ≥ guard end) → `res_valid_44` high from M+1.
- Result handshake at edge K → `in_ready_44` high from K+1. There is no bypass; one frame is in flight at a time.
- Simultaneous events:
  - Timeout and done on the same cycle: done wins and the result is captured.
  - `in_last_44` on the overrun beat: treated as a normal full frame, no error.
- `rst_44` mid-BUSY or mid-RESULT:
  - Immediate return to FILL with the reset values above.
  - The pending result is lost; the MAC is reset by the system in the same event.

## Structure
- Package `bf16_mac_pkg_44`: NUM_ELEMENTS, DATA_W, `bf16_t` (logic [15:0]), loader state enum, BF16 zero constant.
- The MAC shares this package.
- No sub-module required. Optional `bf16_op_bank_44` (indexed write, bulk zero-fill) if the banks are reused by other feeders.

## Test plan
- Full frame: 12 pairs of the standard vectors (A[0]=0x3DCC … B[11]=0x3F0C), `in_last_44` on beat 12. Required: one start pulse one cycle later, banks bit-exact. Model done with result 0x3DCA; `res_data_44`=0x3DCA, no error flags.
- Short frame: 3 pairs of 0x3F80/0x3F80 with last on beat 3. Required: banks[3..11]=0x0000, `err_short_44`=1, model result 0x4040 passed through.
- Overrun: 14 beats, last on beat 14. Required: beats 13–14 dropped with `in_ready_44` high, banks = beats 1–12, `err_overrun_44`=1, single start.
- Result backpressure: `res_ready_44` low for 5 cycles. Required: `res_valid_44` and `res_data_44` stable, `in_ready_44`=0 until the handshake, then 1 the next cycle.
- Hang: done never asserted. Required: `err_timeout_44`=1 after 1000 BUSY cycles, return to FILL, `res_valid_44` never asserted. Also: done held high from a prior frame across start is ignored during the guard.
- Reset mid-BUSY: assert `rst_44` asynchronously. Required: all outputs 0 immediately, a fresh frame completes normally afterwards.
